// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - write-back select, 32x32 register file with write-through read ports, commit counter
// Register 0 is not stored; the other 31 registers and wb_count are the only state.
module wb_regfile #(
  parameter logic [31:0] SP_INIT     = 32'h0000_2ffc,
  parameter logic [31:0] GP_INIT     = 32'h0000_1800,
  parameter logic [31:0] LINK_OFFSET = 32'd4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] WB_c,
  input  logic [31:0] WB_data_read,
  input  logic [31:0] WB_pc,
  input  logic [1:0]  WB_data_write,
  input  logic [4:0]  WB_num_write,
  input  logic        WB_reg_write,
  input  logic [4:0]  rs_num,
  input  logic [4:0]  rt_num,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data,
  output logic [31:0] wb_data,
  input  logic [4:0]  dbg_num,
  output logic [31:0] dbg_data,
  output logic [31:0] wb_count
);

  logic [31:0] regs_q [1:31];
  logic [31:0] count_q;
  logic [31:0] count_d;
  logic        commit;

  always_comb begin
    wb_data = 32'h0;
    case (WB_data_write)
      2'b00:   wb_data = WB_c;
      2'b01:   wb_data = WB_data_read;
      2'b10:   wb_data = WB_pc + LINK_OFFSET;
      default: wb_data = 32'h0;
    endcase
  end

  assign commit  = WB_reg_write && (WB_num_write != 5'd0);
  assign count_d = count_q + 32'd1;

  function automatic logic [31:0] stored(input logic [4:0] n);
    if (n == 5'd0) return 32'h0;
    return regs_q[n];
  endfunction

  // ID sees the value being committed this cycle, so no separate WB forwarding is needed.
  function automatic logic [31:0] read_port(input logic [4:0] n);
    if (n == 5'd0) return 32'h0;
    if (commit && (n == WB_num_write)) return wb_data;
    return regs_q[n];
  endfunction

  assign rs_data  = read_port(rs_num);
  assign rt_data  = read_port(rt_num);
  assign dbg_data = stored(dbg_num);
  assign wb_count = count_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i < 32; i++) begin
        if (i == 28)      regs_q[i] <= GP_INIT;
        else if (i == 29) regs_q[i] <= SP_INIT;
        else              regs_q[i] <= 32'h0;
      end
      count_q <= 32'h0;
    end else if (commit) begin
      regs_q[WB_num_write] <= wb_data;
      count_q              <= count_d;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - directed vector bench for wb_regfile
module tb_wb_regfile;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] WB_c = '0, WB_data_read = '0, WB_pc = '0;
  logic [1:0]  WB_data_write = '0;
  logic [4:0]  WB_num_write = '0;
  logic        WB_reg_write = 1'b0;
  logic [4:0]  rs_num = '0, rt_num = '0, dbg_num = '0;
  logic [31:0] rs_data, rt_data, wb_data, dbg_data, wb_count;

  int checks = 0;
  int errors = 0;

  wb_regfile dut (
    .clock(clock), .reset(reset),
    .WB_c(WB_c), .WB_data_read(WB_data_read), .WB_pc(WB_pc),
    .WB_data_write(WB_data_write), .WB_num_write(WB_num_write), .WB_reg_write(WB_reg_write),
    .rs_num(rs_num), .rt_num(rt_num), .rs_data(rs_data), .rt_data(rt_data),
    .wb_data(wb_data), .dbg_num(dbg_num), .dbg_data(dbg_data), .wb_count(wb_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        we;
    logic [4:0]  num;
    logic [1:0]  sel;
    logic [31:0] c, rd, pc;
    logic [4:0]  rs, rt, dbg;
    logic [31:0] exp_wb, exp_rs, exp_rt, exp_dbg, exp_cnt;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_bundle(input logic we, input logic [4:0] num, input logic [1:0] sel,
                              input logic [31:0] c, input logic [31:0] rd, input logic [31:0] pc);
    WB_reg_write = we; WB_num_write = num; WB_data_write = sel;
    WB_c = c; WB_data_read = rd; WB_pc = pc;
  endtask

  initial begin
    //             we    num    sel    c             rd            pc            rs     rt     dbg    wb            rs            rt            dbg           cnt
    vecs[0]  = '{1'b1, 5'd8,  2'b00, 32'hdeadbeef, 32'h0,        32'h0,        5'd8,  5'd29, 5'd8,  32'hdeadbeef, 32'hdeadbeef, 32'h00002ffc, 32'h0,        32'd0};
    vecs[1]  = '{1'b0, 5'd8,  2'b00, 32'h0,        32'h0,        32'h0,        5'd8,  5'd0,  5'd8,  32'h0,        32'hdeadbeef, 32'h0,        32'hdeadbeef, 32'd1};
    vecs[2]  = '{1'b1, 5'd31, 2'b10, 32'h0,        32'h0,        32'h00003000, 5'd31, 5'd8,  5'd31, 32'h00003004, 32'h00003004, 32'hdeadbeef, 32'h0,        32'd1};
    vecs[3]  = '{1'b1, 5'd30, 2'b10, 32'h0,        32'h0,        32'hfffffffc, 5'd30, 5'd31, 5'd31, 32'h0,        32'h0,        32'h00003004, 32'h00003004, 32'd2};
    vecs[4]  = '{1'b1, 5'd0,  2'b00, 32'h00001234, 32'h0,        32'h0,        5'd0,  5'd0,  5'd0,  32'h00001234, 32'h0,        32'h0,        32'h0,        32'd3};
    vecs[5]  = '{1'b0, 5'd0,  2'b00, 32'h0,        32'h0,        32'h0,        5'd0,  5'd30, 5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        32'd3};
    vecs[6]  = '{1'b1, 5'd9,  2'b01, 32'h11111111, 32'h55aa55aa, 32'h0,        5'd9,  5'd9,  5'd9,  32'h55aa55aa, 32'h55aa55aa, 32'h55aa55aa, 32'h0,        32'd3};
    vecs[7]  = '{1'b1, 5'd9,  2'b11, 32'hffffffff, 32'h1,        32'h100,      5'd9,  5'd9,  5'd9,  32'h0,        32'h0,        32'h0,        32'h55aa55aa, 32'd4};
    vecs[8]  = '{1'b0, 5'd9,  2'b11, 32'h0,        32'h0,        32'h0,        5'd9,  5'd28, 5'd9,  32'h0,        32'h0,        32'h00001800, 32'h0,        32'd5};
    vecs[9]  = '{1'b0, 5'd28, 2'b00, 32'habcdabcd, 32'h0,        32'h0,        5'd28, 5'd1,  5'd28, 32'habcdabcd, 32'h00001800, 32'h0,        32'h00001800, 32'd5};
    vecs[10] = '{1'b1, 5'd28, 2'b00, 32'hcafef00d, 32'h0,        32'h0,        5'd28, 5'd29, 5'd28, 32'hcafef00d, 32'hcafef00d, 32'h00002ffc, 32'h00001800, 32'd5};
    vecs[11] = '{1'b0, 5'd0,  2'b00, 32'h0,        32'h0,        32'h0,        5'd28, 5'd31, 5'd28, 32'h0,        32'hcafef00d, 32'h00003004, 32'hcafef00d, 32'd6};

    // Reset pulse for two cycles, then read back every register.
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    for (int r = 0; r < 32; r++) begin
      dbg_num = 5'(r);
      #1;
      chk($sformatf("reset_reg%0d", r), dbg_data,
          (r == 28) ? 32'h00001800 : (r == 29) ? 32'h00002ffc : 32'h0);
    end
    chk("reset_count", wb_count, 32'd0);

    @(posedge clock); #1;
    for (int v = 0; v < 12; v++) begin
      drive_bundle(vecs[v].we, vecs[v].num, vecs[v].sel, vecs[v].c, vecs[v].rd, vecs[v].pc);
      rs_num = vecs[v].rs; rt_num = vecs[v].rt; dbg_num = vecs[v].dbg;
      @(negedge clock);
      chk($sformatf("v%0d_wb_data", v),  wb_data,  vecs[v].exp_wb);
      chk($sformatf("v%0d_rs_data", v),  rs_data,  vecs[v].exp_rs);
      chk($sformatf("v%0d_rt_data", v),  rt_data,  vecs[v].exp_rt);
      chk($sformatf("v%0d_dbg_data", v), dbg_data, vecs[v].exp_dbg);
      chk($sformatf("v%0d_wb_count", v), wb_count, vecs[v].exp_cnt);
      @(posedge clock); #1;
    end

    // Reset dropped mid-cycle while a write to reg10 is pending.
    drive_bundle(1'b1, 5'd10, 2'b00, 32'ha5a5a5a5, 32'h0, 32'h0);
    rs_num = 5'd10; dbg_num = 5'd28;
    #1;
    chk("pre_reset_bypass", rs_data, 32'ha5a5a5a5);
    chk("pre_reset_reg28", dbg_data, 32'hcafef00d);
    reset = 1'b0;
    #1;
    chk("async_reg28", dbg_data, 32'h00001800);
    chk("async_count", wb_count, 32'd0);
    dbg_num = 5'd31;
    #1;
    chk("async_reg31", dbg_data, 32'h0);
    @(posedge clock); #1;
    dbg_num = 5'd10;
    #1;
    chk("reset_reg10_discarded", dbg_data, 32'h0);
    chk("reset_count_held", wb_count, 32'd0);

    @(negedge clock);
    reset = 1'b1;
    drive_bundle(1'b1, 5'd10, 2'b00, 32'h12345678, 32'h0, 32'h0);
    @(posedge clock); #1;
    drive_bundle(1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0);
    #1;
    chk("post_release_reg10", dbg_data, 32'h12345678);
    chk("post_release_count", wb_count, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
